lcd_timing_gen: RTL and testbench

LCD_TIMING_GEN -- requirements
Module: lcd_timing_gen

---
 rtl/video_types_pkg.sv | 17 +
 rtl/lcd_timing_gen.sv | 99 +++++++++
 tb/tb_lcd_timing_gen.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/video_types_pkg.sv
// video_types: shared LCD mode encoding and default DMG-style timing constants.
package video_types;

    typedef enum logic [1:0] {
        HBLANK = 2'd0,
        VBLANK = 2'd1,
        OAM    = 2'd2,
        XFER   = 2'd3
    } lcd_mode_t;

    localparam int DEF_DOTS_PER_LINE = 456;
    localparam int DEF_VISIBLE_LINES = 144;
    localparam int DEF_TOTAL_LINES   = 154;
    localparam int DEF_OAM_DOTS      = 80;
    localparam int DEF_XFER_DOTS     = 172;

endpackage

// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: dot/line counters, mode decode, draw/vblank/STAT strobes.
// Optional LY==LYC compare is built only when LCD_LYC_COMPARE_EN is defined.
module lcd_timing_gen
    import video_types::*;
#(
    parameter int DOTS_PER_LINE = DEF_DOTS_PER_LINE,
    parameter int VISIBLE_LINES = DEF_VISIBLE_LINES,
    parameter int TOTAL_LINES   = DEF_TOTAL_LINES,
    parameter int OAM_DOTS      = DEF_OAM_DOTS,
    parameter int XFER_DOTS     = DEF_XFER_DOTS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lcd_enable,
    input  logic [7:0] lyc,
    input  logic [3:0] stat_ie,
    output logic       drawline,
    output logic [7:0] ly,
    output logic [1:0] mode,
    output logic       lyc_match,
    output logic       vblank_irq,
    output logic       stat_irq
);

    localparam int DW = $clog2(DOTS_PER_LINE);
    localparam logic [DW-1:0] DOT_LAST = DW'(DOTS_PER_LINE - 1);
    localparam logic [DW-1:0] OAM_END  = DW'(OAM_DOTS);
    localparam logic [DW-1:0] XFER_END = DW'(OAM_DOTS + XFER_DOTS);
    localparam logic [7:0]    VIS      = 8'(VISIBLE_LINES);
    localparam logic [7:0]    LINE_LAST = 8'(TOTAL_LINES - 1);

    logic [DW-1:0] r_dot;
    logic [7:0]    r_line;
    logic          r_running;
    logic          r_stat_prev;
    lcd_mode_t     w_mode;
    logic          w_visible;
    logic          w_lyc_match;
    logic          w_lyc_stat;
    logic          w_stat_line;

    // Counters advance only once running was already set, so enable costs one idle cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dot       <= '0;
            r_line      <= '0;
            r_running   <= 1'b0;
            r_stat_prev <= 1'b0;
        end else begin
            r_stat_prev <= w_stat_line;
            if (!lcd_enable) begin
                r_dot     <= '0;
                r_line    <= '0;
                r_running <= 1'b0;
            end else begin
                r_running <= 1'b1;
                if (r_running) begin
                    if (r_dot == DOT_LAST) begin
                        r_dot  <= '0;
                        r_line <= (r_line == LINE_LAST) ? 8'd0 : r_line + 8'd1;
                    end else begin
                        r_dot <= r_dot + 1'b1;
                    end
                end
            end
        end
    end

`ifdef LCD_LYC_COMPARE_EN
    assign w_lyc_match = r_running && (r_line == lyc);
    assign w_lyc_stat  = w_lyc_match & stat_ie[3];
`else
    logic w_unused_lyc;
    assign w_unused_lyc = ^{lyc, stat_ie[3]};
    assign w_lyc_match  = 1'b0;
    assign w_lyc_stat   = 1'b0;
`endif

    // Mode and STAT line decoded straight from registered state; STAT is silent while halted.
    always_comb begin
        w_visible   = r_line < VIS;
        w_mode      = !r_running ? HBLANK :
                      !w_visible ? VBLANK :
                      (r_dot < OAM_END)  ? OAM :
                      (r_dot < XFER_END) ? XFER : HBLANK;
        w_stat_line = r_running & (((w_mode == HBLANK) & stat_ie[0]) |
                                   ((w_mode == VBLANK) & stat_ie[1]) |
                                   ((w_mode == OAM)    & stat_ie[2]) |
                                   w_lyc_stat);
    end

    assign ly         = r_line;
    assign mode       = w_mode;
    assign lyc_match  = w_lyc_match;
    assign drawline   = r_running && w_visible && (r_dot == OAM_END);
    assign vblank_irq = r_running && (r_line == VIS) && (r_dot == '0);
    assign stat_irq   = w_stat_line & ~r_stat_prev;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb_lcd_timing_gen: directed checks of the LCD timing generator at default timing,
// plus a short-line instance used to reach the vblank region quickly for the async-reset check.
module tb_lcd_timing_gen;

`ifdef LCD_LYC_COMPARE_EN
    localparam bit LYC_EN = 1'b1;
`else
    localparam bit LYC_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       lcd_enable = 1'b0;
    logic [7:0] lyc = 8'd10;
    logic [3:0] stat_ie = 4'b0101;
    logic       drawline, lyc_match, vblank_irq, stat_irq;
    logic [7:0] ly;
    logic [1:0] mode;

    logic       f_reset = 1'b1;
    logic       f_enable = 1'b0;
    logic [7:0] f_lyc = 8'd200;
    logic [3:0] f_ie = 4'b0000;
    logic       f_drawline, f_lyc_match, f_vblank, f_stat;
    logic [7:0] f_ly;
    logic [1:0] f_mode;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lcd_timing_gen u_dut (
        .clk(clk), .reset(reset), .lcd_enable(lcd_enable), .lyc(lyc), .stat_ie(stat_ie),
        .drawline(drawline), .ly(ly), .mode(mode), .lyc_match(lyc_match),
        .vblank_irq(vblank_irq), .stat_irq(stat_irq)
    );

    lcd_timing_gen #(.DOTS_PER_LINE(8), .OAM_DOTS(2), .XFER_DOTS(3)) u_fast (
        .clk(clk), .reset(f_reset), .lcd_enable(f_enable), .lyc(f_lyc), .stat_ie(f_ie),
        .drawline(f_drawline), .ly(f_ly), .mode(f_mode), .lyc_match(f_lyc_match),
        .vblank_irq(f_vblank), .stat_irq(f_stat)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // First running line after enable, with stat_ie=0101: OAM start fires, HBLANK start fires.
    task automatic run_line0();
        for (int t = 0; t < 456; t++) begin
            step();
            chk("l0_mode", mode, (t < 80) ? 2 : (t < 252) ? 3 : 0);
            chk("l0_drawline", drawline, t == 80);
            chk("l0_stat", stat_irq, t == 0 || t == 252);
            chk("l0_ly", ly, 0);
        end
        step();
        chk("l1_ly", ly, 1);
        chk("l1_mode", mode, 2);
        chk("l1_oam_no_refire", stat_irq, 0);
    endtask

    initial begin
        step();
        step();
        chk("rst_ly", ly, 0);
        chk("rst_mode", mode, 0);
        chk("rst_draw", drawline, 0);
        chk("rst_lycm", lyc_match, 0);
        chk("rst_vbl", vblank_irq, 0);
        chk("rst_stat", stat_irq, 0);

        reset = 1'b0;
        lcd_enable = 1'b1;
        run_line0();

        for (int d = 1; d < 456; d++) begin
            step();
            chk("l1_stat", stat_irq, d == 252);
        end
        stat_ie = 4'b1000;

        for (int t = 912; t <= 70224; t++) begin
            step();
            chk("fr_vblank", vblank_irq, t == 65664);
            chk("fr_stat", stat_irq, LYC_EN && t == 4560);
            if (t == 4559) chk("lyc_pre", lyc_match, 0);
            if (t == 4560) begin
                chk("lyc_ly", ly, 10);
                chk("lyc_match", lyc_match, LYC_EN);
            end
            if (t == 65664) begin
                chk("vbl_ly", ly, 144);
                chk("vbl_mode", mode, 1);
            end
            if (t == 70223) chk("wrap_pre", ly, 153);
            if (t == 70224) begin
                chk("wrap_ly", ly, 0);
                chk("wrap_mode", mode, 2);
            end
        end

        for (int i = 0; i < 2380; i++) step();
        chk("dis_pre_ly", ly, 5);
        chk("dis_pre_mode", mode, 3);
        stat_ie = 4'b0101;
        lcd_enable = 1'b0;
        step();
        chk("dis_ly", ly, 0);
        chk("dis_mode", mode, 0);
        chk("dis_draw", drawline, 0);
        chk("dis_vbl", vblank_irq, 0);
        chk("dis_stat", stat_irq, 0);
        chk("dis_lycm", lyc_match, 0);
        lcd_enable = 1'b1;
        run_line0();

        f_reset = 1'b0;
        f_enable = 1'b1;
        for (int t = 0; t <= 1200; t++) begin
            step();
            chk("f_vblank", f_vblank, t == 1152);
        end
        chk("f_ly150", f_ly, 150);
        chk("f_mode150", f_mode, 1);
        #3;
        f_reset = 1'b1;
        #1;
        chk("ar_ly", f_ly, 0);
        chk("ar_mode", f_mode, 0);
        chk("ar_draw", f_drawline, 0);
        chk("ar_lycm", f_lyc_match, 0);
        chk("ar_vbl", f_vblank, 0);
        chk("ar_stat", f_stat, 0);
        #1;
        f_reset = 1'b0;
        step();
        chk("rs_ly", f_ly, 0);
        chk("rs_mode0", f_mode, 2);
        step();
        chk("rs_mode1", f_mode, 2);
        step();
        chk("rs_mode2", f_mode, 3);
        chk("rs_draw", f_drawline, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
